data_mem_copy_engine: RTL and testbench

Initiator-side block that drives the data-memory bank manager's port to copy a block of 32-bit words from a source word address to a destination word address.
- Memory side: generates address, write data and write enable; consumes the manager's read data.
- Read model: one-cycle read latency. The bank-select output mux uses the current address.
- Placement: alongside the CPU on the data-memory bus. Bus arbitration is outside this block.

---
 rtl/data_mem_pkg.sv | 22 ++
 rtl/data_mem_copy_engine_if.sv | 24 ++
 rtl/data_mem_copy_engine.sv | 116 +++++++++++
 tb/tb_data_mem_copy_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory copy engine.
package data_mem_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 16;

  // Banks 0-2 are populated; bank 3 is absent.
  localparam logic [ADDR_W-1:0] MAX_ADDR = 18'h2FFFF;

  localparam int unsigned BANK_SEL_HI = 17;
  localparam int unsigned BANK_SEL_LO = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdCap,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/data_mem_copy_engine_if.sv
// Data-memory bus between an initiator and the bank manager.
interface data_mem_copy_engine_if;
  import data_mem_pkg::*;

  logic [31:0]       mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_address,
    output mem_wdata,
    output mem_wren,
    input  mem_rdata
  );

  modport slave (
    input  mem_address,
    input  mem_wdata,
    input  mem_wren,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_copy_engine.sv
// Block copy engine: reads one word, writes it, advances; 3 cycles per word.
module data_mem_copy_engine
  import data_mem_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   start_i,
  input  logic [31:0]            src_i,
  input  logic [31:0]            dst_i,
  input  logic [LEN_W-1:0]       len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  data_mem_copy_engine_if.master mem
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                err_q, err_d;

  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic        range_ok;

  // Last word address of each span in 33 bits so a huge address cannot wrap past the check.
  always_comb begin
    src_end  = {1'b0, src_i} + {17'b0, len_i} - 33'd1;
    dst_end  = {1'b0, dst_i} + {17'b0, len_i} - 33'd1;
    range_ok = (src_i[31:ADDR_W] == '0) && (dst_i[31:ADDR_W] == '0) &&
               (src_end <= {15'b0, MAX_ADDR}) && (dst_end <= {15'b0, MAX_ADDR});
  end

  // Next-state logic for the copy sequencer.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    remain_d  = remain_q;
    buf_d     = buf_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          src_ptr_d = src_i[ADDR_W-1:0];
          dst_ptr_d = dst_i[ADDR_W-1:0];
          remain_d  = len_i;
          if (len_i == '0) begin
            err_d   = 1'b0;
            state_d = StDone;
          end else if (!range_ok) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StRdAddr;
          end
        end
      end
      StRdAddr: state_d = StRdCap;
      StRdCap: begin
        buf_d   = mem.mem_rdata;
        state_d = StWr;
      end
      StWr: begin
        src_ptr_d = src_ptr_q + ADDR_W'(1);
        dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        remain_d  = remain_q - LEN_W'(1);
        state_d   = (remain_q == LEN_W'(1)) ? StDone : StRdAddr;
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q   <= StIdle;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      remain_q  <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      remain_q  <= remain_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode registered state only; the source address is held through
  // RdCap because the manager's bank mux decodes the live address.
  always_comb begin
    busy_o          = (state_q != StIdle);
    done_o          = (state_q == StDone);
    err_o           = (state_q == StDone) && err_q;
    mem.mem_wren    = (state_q == StWr);
    mem.mem_wdata   = buf_q;
    mem.mem_address = '0;
    unique case (state_q)
      StRdAddr, StRdCap: mem.mem_address = {14'b0, src_ptr_q};
      StWr:              mem.mem_address = {14'b0, dst_ptr_q};
      default:           mem.mem_address = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_copy_engine.sv
// Scoreboard bench for data_mem_copy_engine with a banked one-cycle-latency memory.
module tb_data_mem_copy_engine;
  import data_mem_pkg::*;

  localparam int unsigned MEM_WORDS = 32'h30000;

  logic             CLK = 1'b0;
  logic             RST_n = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      src_i = '0;
  logic [31:0]      dst_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             busy_o, done_o, err_o;

  data_mem_copy_engine_if mem_if ();

  data_mem_copy_engine dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .start_i (start_i),
    .src_i   (src_i),
    .dst_i   (dst_i),
    .len_i   (len_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .mem     (mem_if)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int unsigned a);
    if (a >= 32'h10 && a <= 32'h13) return 32'hA0 + (a - 32'h10);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Bus-side memory: each bank registers its read word; output mux uses the live address.
  bit [31:0] mem [MEM_WORDS];
  bit [31:0] bank_q [4];
  bit        mem_ready = 1'b0;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_if.mem_wren && mem_if.mem_address < MEM_WORDS)
        mem[mem_if.mem_address[17:0]] <= mem_if.mem_wdata;
      bank_q[mem_if.mem_address[17:16]] <=
        (mem_if.mem_address < MEM_WORDS) ? mem[mem_if.mem_address[17:0]] : 32'hDEAD_BEEF;
    end
  end
  assign mem_if.mem_rdata = bank_q[mem_if.mem_address[17:16]];

  // Reference model memory, updated by plain sequential copy.
  bit [31:0] ref_mem [MEM_WORDS];

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  exp_t dq[$];
  bit   mon_en = 1'b0;

  // Monitor: classify each cycle's bus activity and check against the queued expectations.
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (done_o) begin
        chk("done_expected", dq.size() != 0, 1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_err", err_o, e.err);
          chk("done_no_wren", mem_if.mem_wren, 0);
        end
      end else if (mem_if.mem_wren) begin
        chk("write_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("write_addr", mem_if.mem_address, e.addr);
          chk("write_data", mem_if.mem_wdata, e.data);
        end
      end else if (busy_o) begin
        chk("read_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          e = rq.pop_front();
          chk("read_cycle", cyc, e.cyc);
          chk("read_addr", mem_if.mem_address, e.addr);
        end
      end else begin
        chk("idle_addr", mem_if.mem_address, 0);
        chk("idle_err", err_o, 0);
      end
    end
  end

  // Issue one request; poke_c pulses start in that cycle, abort_c resets at the edge ending it.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int poke_c, input int abort_c);
    int   e0, lim, last;
    bit   rej;
    exp_t e;
    @(negedge CLK);
    for (int i = 0; i < 100 && busy_o; i++) @(negedge CLK);
    chk("idle_before_start", busy_o, 0);
    e0  = cyc + 1;
    rej = (len != 0) && ((src >> 18) != 0 || (dst >> 18) != 0 ||
                         ({32'b0, src} + 64'(len) - 1) > 64'h2FFFF ||
                         ({32'b0, dst} + 64'(len) - 1) > 64'h2FFFF);
    lim = (abort_c > 0) ? abort_c : 1 << 30;
    if (!rej) begin
      for (int k = 0; k < len; k++) begin
        e.err = 1'b0;
        e.data = '0;
        e.addr = src + k;
        if (3 * k + 1 <= lim) begin e.cyc = e0 + 3 * k;     rq.push_back(e); end
        if (3 * k + 2 <= lim) begin e.cyc = e0 + 3 * k + 1; rq.push_back(e); end
        if (3 * k + 3 <= lim) begin
          e.data = ref_mem[src + k];
          ref_mem[dst + k] = e.data;
          e.addr = dst + k;
          e.cyc = e0 + 3 * k + 2;
          wq.push_back(e);
        end
      end
    end
    if (abort_c == 0) begin
      e.cyc  = (len == 0 || rej) ? e0 : e0 + 3 * len;
      e.err  = rej;
      e.addr = '0;
      e.data = '0;
      dq.push_back(e);
    end
    start_i = 1'b1;
    src_i   = src;
    dst_i   = dst;
    len_i   = LEN_W'(len);
    @(posedge CLK);
    #1;
    start_i = 1'b0;
    src_i   = $urandom;
    dst_i   = $urandom;
    len_i   = LEN_W'($urandom);
    last = (abort_c > 0) ? abort_c : ((len == 0 || rej) ? 1 : 3 * len + 1);
    for (int c = 1; c <= last; c++) begin
      @(negedge CLK);
      start_i = (c == poke_c);
      if (c == abort_c) RST_n = 1'b0;
    end
    @(negedge CLK);
    start_i = 1'b0;
    RST_n   = 1'b1;
    chk("after_busy", busy_o, 0);
    chk("after_wren", mem_if.mem_wren, 0);
    chk("after_done", done_o, 0);
    chk("reads_drained", rq.size(), 0);
    chk("writes_drained", wq.size(), 0);
    chk("dones_drained", dq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_bad_mem;
    int          len, r;
    logic [31:0] src, dst;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wren", mem_if.mem_wren, 0);
    chk("rst_addr", mem_if.mem_address, 0);
    RST_n  = 1'b1;
    mon_en = 1'b1;

    run_copy(32'h10, 32'h100, 4, 0, 0);          // basic copy
    run_copy(32'h0FFFE, 32'h1FFFF, 3, 0, 0);     // bank crossing
    run_copy(32'h20, 32'h40, 0, 0, 0);           // zero length
    run_copy(32'h2FFFF, 32'h10, 2, 0, 0);        // source overruns top
    run_copy(32'h10, 32'h30000, 2, 0, 0);        // destination in absent bank
    run_copy(32'h200, 32'h300, 4, 5, 0);         // start while busy
    run_copy(32'h400, 32'h500, 4, 0, 7);         // reset mid-transfer
    run_copy(32'h600, 32'h700, 1, 0, 0);         // recovery after reset
    run_copy(32'h2FFFE, 32'h0, 2, 0, 0);         // exactly at top: accepted

    for (int t = 0; t < 30; t++) begin
      r   = $urandom_range(0, 9);
      len = (r == 0) ? 0 : $urandom_range(1, 6);
      src = $urandom_range(0, 32'h2FFF0);
      dst = $urandom_range(0, 32'h2FFF0);
      if (r == 1) dst = src + $urandom_range(1, 3);
      if (r == 2) src = 32'h2FFFF - $urandom_range(0, 2);
      if (r == 3) dst = dst | (32'h1 << $urandom_range(18, 31));
      if (r == 4) dst = 32'h30000 + $urandom_range(0, 4);
      run_copy(src, dst, len, 0, 0);
    end

    @(negedge CLK);
    n_bad_mem = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) if (mem[i] != ref_mem[i]) n_bad_mem++;
    chk("final_mem_mismatches", n_bad_mem, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
